// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests one instruction word per fetch_start,
// holds it in the instruction register until it is retired, and advances or
// redirects the program counter on retirement. A fetch that never sees an ack
// completes with a HALT instruction and raises a sticky error flag. halt
// freezes the stage until the next reset.
module instr_fetch #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               fetch_start,
  input  logic               pc_enable,
  input  logic               halt,
  input  logic               branch_valid,
  input  logic [PC_W-1:0]    branch_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [3:0]         opcode,
  output logic [3:0]         rd,
  output logic [3:0]         rs,
  output logic [7:0]         imm,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_VALID  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // Word substituted for a fetch that timed out: HALT opcode, all other fields zero.
  localparam logic [INSTR_W-1:0] HALT_WORD_C = {4'hF, {(INSTR_W-4){1'b0}}};
  localparam logic [PC_W-1:0]    PC_ONE_C    = {{(PC_W-1){1'b0}}, 1'b1};
  // Wait-count value seen during the last ack-less cycle before giving up.
  localparam logic [7:0]         WAIT_LAST_C = 8'(TIMEOUT - 1);

  state_t             state_r, state_s;
  logic [PC_W-1:0]    pc_r, pc_s;
  logic [INSTR_W-1:0] ir_r, ir_s;
  logic               instr_valid_r, instr_valid_s;
  logic               imem_req_r, imem_req_s;
  logic               fetch_err_r, fetch_err_s;
  logic [7:0]         wait_cnt_r, wait_cnt_s;

  // Next-state and next-register computation; halt overrides every other request.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    ir_s          = ir_r;
    instr_valid_s = instr_valid_r;
    fetch_err_s   = fetch_err_r;
    wait_cnt_s    = wait_cnt_r;
    if (halt) begin
      state_s = ST_HALTED;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fetch_start) begin
            state_s    = ST_REQ;
            wait_cnt_s = 8'd0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (imem_ack) begin
            ir_s          = imem_rdata;
            instr_valid_s = 1'b1;
            state_s       = ST_VALID;
          end else if (wait_cnt_r == WAIT_LAST_C) begin
            ir_s          = HALT_WORD_C;
            instr_valid_s = 1'b1;
            fetch_err_s   = 1'b1;
            wait_cnt_s    = 8'd0;
            state_s       = ST_VALID;
          end else begin
            wait_cnt_s = wait_cnt_r + 8'd1;
          end
        end
        ST_VALID: begin
          if (pc_enable) begin
            if (branch_valid) begin
              pc_s = branch_target;
            end else begin
              pc_s = pc_r + PC_ONE_C;
            end
            instr_valid_s = 1'b0;
            state_s       = ST_IDLE;
          end else begin
            state_s = ST_VALID;
          end
        end
        ST_HALTED: begin
          state_s = ST_HALTED;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
    // The request line is registered from the state being entered, so it is
    // high exactly while the state register holds REQ.
    imem_req_s = (state_s == ST_REQ);
  end

  // State and datapath registers; reset clears everything at once, including
  // an outstanding memory request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      pc_r          <= {PC_W{1'b0}};
      ir_r          <= {INSTR_W{1'b0}};
      instr_valid_r <= 1'b0;
      imem_req_r    <= 1'b0;
      fetch_err_r   <= 1'b0;
      wait_cnt_r    <= 8'd0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      ir_r          <= ir_s;
      instr_valid_r <= instr_valid_s;
      imem_req_r    <= imem_req_s;
      fetch_err_r   <= fetch_err_s;
      wait_cnt_r    <= wait_cnt_s;
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign instr_valid = instr_valid_r;
  assign fetch_err   = fetch_err_r;
  assign opcode      = ir_r[15:12];
  assign rd          = ir_r[11:8];
  assign rs          = ir_r[7:4];
  assign imm         = ir_r[7:0];

endmodule
